// File: rtl/wb_arbiter_2m1s.sv
// Two-master / one-slave Wishbone arbiter: the instruction cache (m0) and the data cache (m1)
// share unified memory. The grant is registered, the request path is a combinational mux, and
// responses are routed back to the granted master only.
module wb_arbiter_2m1s #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int BLW = 10
) (
    input  logic           clk,
    input  logic           reset,

    input  logic [DW-1:0]  m0_wbd_dat_i,
    input  logic [AW-1:0]  m0_wbd_adr_i,
    input  logic [3:0]     m0_wbd_sel_i,
    input  logic           m0_wbd_we_i,
    input  logic           m0_wbd_cyc_i,
    input  logic           m0_wbd_stb_i,
    output logic [DW-1:0]  m0_wbd_dat_o,
    output logic           m0_wbd_ack_o,
    output logic           m0_wbd_lack_o,
    output logic           m0_wbd_err_o,

    input  logic [DW-1:0]  m1_wbd_dat_i,
    input  logic [AW-1:0]  m1_wbd_adr_i,
    input  logic [3:0]     m1_wbd_sel_i,
    input  logic           m1_wbd_we_i,
    input  logic           m1_wbd_cyc_i,
    input  logic           m1_wbd_stb_i,
    input  logic [BLW-1:0] m1_wbd_bl_i,
    input  logic           m1_wbd_bry_i,
    output logic [DW-1:0]  m1_wbd_dat_o,
    output logic           m1_wbd_ack_o,
    output logic           m1_wbd_lack_o,
    output logic           m1_wbd_err_o,

    input  logic [DW-1:0]  s_wbd_dat_i,
    input  logic           s_wbd_ack_i,
    input  logic           s_wbd_lack_i,
    output logic [DW-1:0]  s_wbd_dat_o,
    output logic [AW-1:0]  s_wbd_adr_o,
    output logic [3:0]     s_wbd_sel_o,
    output logic           s_wbd_we_o,
    output logic           s_wbd_cyc_o,
    output logic           s_wbd_stb_o,
    output logic [BLW-1:0] s_wbd_bl_o,
    output logic           s_wbd_bry_o
);

    // state     | meaning
    // GNT_NONE  | slave idle, no master owns the bus
    // GNT_M0    | instruction-cache port owns the slave
    // GNT_M1    | data-cache port owns the slave
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    logic [1:0] gnt_q;
    logic [1:0] gnt_d;
    logic       last_m1_q;   // 1 when m1 was served most recently; decides ties from idle

    always_comb begin
        gnt_d = gnt_q;
        case (gnt_q)
            GNT_NONE: begin
                if (m0_wbd_cyc_i && m1_wbd_cyc_i)
                    gnt_d = last_m1_q ? GNT_M0 : GNT_M1;
                else if (m0_wbd_cyc_i)
                    gnt_d = GNT_M0;
                else if (m1_wbd_cyc_i)
                    gnt_d = GNT_M1;
                else
                    gnt_d = GNT_NONE;
            end
            GNT_M0: begin
                if (!m0_wbd_cyc_i)
                    gnt_d = m1_wbd_cyc_i ? GNT_M1 : GNT_NONE;
            end
            GNT_M1: begin
                if (!m1_wbd_cyc_i)
                    gnt_d = m0_wbd_cyc_i ? GNT_M0 : GNT_NONE;
            end
            default: gnt_d = GNT_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q     <= GNT_NONE;
            last_m1_q <= 1'b0;
        end else begin
            gnt_q <= gnt_d;
            if (gnt_d == GNT_M1)
                last_m1_q <= 1'b1;
            else if (gnt_d == GNT_M0)
                last_m1_q <= 1'b0;
        end
    end

    // Request mux; the instruction port never bursts, so it presents a single-beat, always-ready burst.
    always_comb begin
        s_wbd_dat_o = '0;
        s_wbd_adr_o = '0;
        s_wbd_sel_o = '0;
        s_wbd_we_o  = 1'b0;
        s_wbd_cyc_o = 1'b0;
        s_wbd_stb_o = 1'b0;
        s_wbd_bl_o  = '0;
        s_wbd_bry_o = 1'b0;
        case (gnt_q)
            GNT_M0: begin
                s_wbd_dat_o = m0_wbd_dat_i;
                s_wbd_adr_o = m0_wbd_adr_i;
                s_wbd_sel_o = m0_wbd_sel_i;
                s_wbd_we_o  = m0_wbd_we_i;
                s_wbd_cyc_o = m0_wbd_cyc_i;
                s_wbd_stb_o = m0_wbd_stb_i;
                s_wbd_bl_o  = BLW'(1);
                s_wbd_bry_o = 1'b1;
            end
            GNT_M1: begin
                s_wbd_dat_o = m1_wbd_dat_i;
                s_wbd_adr_o = m1_wbd_adr_i;
                s_wbd_sel_o = m1_wbd_sel_i;
                s_wbd_we_o  = m1_wbd_we_i;
                s_wbd_cyc_o = m1_wbd_cyc_i;
                s_wbd_stb_o = m1_wbd_stb_i;
                s_wbd_bl_o  = m1_wbd_bl_i;
                s_wbd_bry_o = m1_wbd_bry_i;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; only the per-master ack qualifies it.
    assign m0_wbd_dat_o  = s_wbd_dat_i;
    assign m1_wbd_dat_o  = s_wbd_dat_i;
    assign m0_wbd_ack_o  = s_wbd_ack_i  && (gnt_q == GNT_M0);
    assign m0_wbd_lack_o = s_wbd_lack_i && (gnt_q == GNT_M0);
    assign m1_wbd_ack_o  = s_wbd_ack_i  && (gnt_q == GNT_M1);
    assign m1_wbd_lack_o = s_wbd_lack_i && (gnt_q == GNT_M1);
    assign m0_wbd_err_o  = 1'b0;
    assign m1_wbd_err_o  = 1'b0;

endmodule

// File: tb/tb_wb_arbiter_2m1s.sv
// Bench for wb_arbiter_2m1s: directed scenarios followed by random traffic, all outputs compared
// every cycle against an ownership model built from the arbitration rules.
module tb_wb_arbiter_2m1s;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int BLW = 10;

    logic           clk;
    logic           reset;
    logic [DW-1:0]  m0_dat_i, m1_dat_i, s_dat_i;
    logic [AW-1:0]  m0_adr_i, m1_adr_i;
    logic [3:0]     m0_sel_i, m1_sel_i;
    logic           m0_we_i, m0_cyc_i, m0_stb_i;
    logic           m1_we_i, m1_cyc_i, m1_stb_i;
    logic [BLW-1:0] m1_bl_i;
    logic           m1_bry_i;
    logic           s_ack_i, s_lack_i;

    logic [DW-1:0]  m0_dat_o, m1_dat_o, s_dat_o;
    logic [AW-1:0]  s_adr_o;
    logic [3:0]     s_sel_o;
    logic           m0_ack_o, m0_lack_o, m0_err_o;
    logic           m1_ack_o, m1_lack_o, m1_err_o;
    logic           s_we_o, s_cyc_o, s_stb_o, s_bry_o;
    logic [BLW-1:0] s_bl_o;

    int errors = 0;
    int checks = 0;

    // Reference model: owner 0 = nobody, 1 = master 0, 2 = master 1; last = most recently served.
    int owner = 0;
    int last  = 1;

    wb_arbiter_2m1s #(.DW(DW), .AW(AW), .BLW(BLW)) dut (
        .clk(clk), .reset(reset),
        .m0_wbd_dat_i(m0_dat_i), .m0_wbd_adr_i(m0_adr_i), .m0_wbd_sel_i(m0_sel_i),
        .m0_wbd_we_i(m0_we_i), .m0_wbd_cyc_i(m0_cyc_i), .m0_wbd_stb_i(m0_stb_i),
        .m0_wbd_dat_o(m0_dat_o), .m0_wbd_ack_o(m0_ack_o), .m0_wbd_lack_o(m0_lack_o),
        .m0_wbd_err_o(m0_err_o),
        .m1_wbd_dat_i(m1_dat_i), .m1_wbd_adr_i(m1_adr_i), .m1_wbd_sel_i(m1_sel_i),
        .m1_wbd_we_i(m1_we_i), .m1_wbd_cyc_i(m1_cyc_i), .m1_wbd_stb_i(m1_stb_i),
        .m1_wbd_bl_i(m1_bl_i), .m1_wbd_bry_i(m1_bry_i),
        .m1_wbd_dat_o(m1_dat_o), .m1_wbd_ack_o(m1_ack_o), .m1_wbd_lack_o(m1_lack_o),
        .m1_wbd_err_o(m1_err_o),
        .s_wbd_dat_i(s_dat_i), .s_wbd_ack_i(s_ack_i), .s_wbd_lack_i(s_lack_i),
        .s_wbd_dat_o(s_dat_o), .s_wbd_adr_o(s_adr_o), .s_wbd_sel_o(s_sel_o),
        .s_wbd_we_o(s_we_o), .s_wbd_cyc_o(s_cyc_o), .s_wbd_stb_o(s_stb_o),
        .s_wbd_bl_o(s_bl_o), .s_wbd_bry_o(s_bry_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clock();
        if (reset) begin
            owner = 0;
            last  = 1;
        end else begin
            if (owner == 1 && !m0_cyc_i) owner = 0;
            if (owner == 2 && !m1_cyc_i) owner = 0;
            if (owner == 0) begin
                if (m0_cyc_i && m1_cyc_i) owner = 3 - last;
                else if (m0_cyc_i)        owner = 1;
                else if (m1_cyc_i)        owner = 2;
            end
            if (owner != 0) last = owner;
        end
    endtask

    task automatic check_all();
        logic g0, g1;
        g0 = (owner == 1);
        g1 = (owner == 2);
        chk("s_cyc", 64'(s_cyc_o), 64'((g0 & m0_cyc_i) | (g1 & m1_cyc_i)));
        chk("s_stb", 64'(s_stb_o), 64'((g0 & m0_stb_i) | (g1 & m1_stb_i)));
        chk("s_adr", 64'(s_adr_o), g0 ? 64'(m0_adr_i) : g1 ? 64'(m1_adr_i) : 64'd0);
        chk("s_dat", 64'(s_dat_o), g0 ? 64'(m0_dat_i) : g1 ? 64'(m1_dat_i) : 64'd0);
        chk("s_sel", 64'(s_sel_o), g0 ? 64'(m0_sel_i) : g1 ? 64'(m1_sel_i) : 64'd0);
        chk("s_we",  64'(s_we_o),  64'((g0 & m0_we_i) | (g1 & m1_we_i)));
        chk("s_bl",  64'(s_bl_o),  g0 ? 64'd1 : g1 ? 64'(m1_bl_i) : 64'd0);
        chk("s_bry", 64'(s_bry_o), 64'(g0 | (g1 & m1_bry_i)));
        chk("m0_ack",  64'(m0_ack_o),  64'(g0 & s_ack_i));
        chk("m0_lack", 64'(m0_lack_o), 64'(g0 & s_lack_i));
        chk("m1_ack",  64'(m1_ack_o),  64'(g1 & s_ack_i));
        chk("m1_lack", 64'(m1_lack_o), 64'(g1 & s_lack_i));
        chk("err", {m0_err_o, m1_err_o}, 64'd0);
        chk("m0_dat", 64'(m0_dat_o), 64'(s_dat_i));
        chk("m1_dat", 64'(m1_dat_o), 64'(s_dat_i));
    endtask

    // One clock: model follows the edge, outputs compared 2 ns later with inputs unchanged.
    task automatic step();
        @(posedge clk);
        model_clock();
        #2;
        check_all();
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        m0_dat_i = '0; m0_adr_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_dat_i = '0; m1_adr_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        m1_bl_i = '0; m1_bry_i = 0;
        s_dat_i = '0; s_ack_i = 0; s_lack_i = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        s_dat_i = 32'hCAFE_F00D;
        #1;
        check_all();
        chk("rst_m0_dat", 64'(m0_dat_o), 64'h0000_0000_CAFE_F00D);
        do_reset();

        // Master 0 read alone.
        m0_adr_i = 32'h0000_0010; m0_cyc_i = 1; m0_stb_i = 1; m0_sel_i = 4'hF;
        settle();
        chk("m0rd_no_early_cyc", 64'(s_cyc_o), 64'd0);
        step();
        chk("m0rd_adr", 64'(s_adr_o), 64'h10);
        chk("m0rd_bl", 64'(s_bl_o), 64'd1);
        s_ack_i = 1; s_lack_i = 1; s_dat_i = 32'h1234_5678;
        settle();
        chk("m0rd_ack", {m0_ack_o, m1_ack_o}, 64'b10);
        chk("m0rd_dat", 64'(m0_dat_o), 64'h1234_5678);
        step();
        idle_inputs();
        step();

        // Master 1 write alone.
        m1_adr_i = 32'h1000; m1_dat_i = 32'h1; m1_sel_i = 4'hF; m1_we_i = 1;
        m1_bl_i = 10'd1; m1_bry_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        chk("m1wr_req", {s_adr_o, s_dat_o}, {32'h1000, 32'h1});
        chk("m1wr_we_sel", {s_we_o, s_sel_o}, 64'h1F);
        s_ack_i = 1;
        settle();
        chk("m1wr_ack", {m0_ack_o, m1_ack_o}, 64'b01);
        step();
        idle_inputs();
        step();

        // Simultaneous requests right after reset: m1 first, then a no-gap handoff to m0.
        do_reset();
        m0_adr_i = 32'hA0A0_0000; m0_cyc_i = 1; m0_stb_i = 1;
        m1_adr_i = 32'hB1B1_0000; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        chk("tie_first_m1", 64'(s_adr_o), 64'hB1B1_0000);
        step();
        m1_cyc_i = 0; m1_stb_i = 0;
        step();
        chk("handoff_m0", {s_cyc_o, s_adr_o}, {1'b1, 32'hA0A0_0000});

        // Grant stability: m1 raising cyc while m0 owns the bus changes nothing.
        m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stable_adr", 64'(s_adr_o), 64'hA0A0_0000);
            chk("stable_m1_ack", 64'(m1_ack_o), 64'd0);
        end
        s_ack_i = 0;

        // Repeated ties: the released master drops cyc for one cycle; owners alternate.
        m0_cyc_i = 0;
        for (int r = 0; r < 4; r++) begin
            step();
            chk("alternate", 64'(s_adr_o), (r % 2 == 0) ? 64'hB1B1_0000 : 64'hA0A0_0000);
            m0_cyc_i = (r % 2 == 0);
            m1_cyc_i = (r % 2 != 0);
        end

        // Asynchronous reset between edges while m1 owns the slave.
        idle_inputs();
        step();
        step();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h55;
        step();
        chk("pre_rst_cyc", 64'(s_cyc_o), 64'd1);
        reset = 1'b1;
        #1;
        owner = 0;
        last  = 1;
        chk("async_rst", {s_cyc_o, s_stb_o}, 64'd0);
        check_all();
        @(negedge clk);
        reset = 1'b0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h66;
        step();
        chk("rst_ptr_tie_m1", 64'(s_adr_o), 64'h55);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(0, 3) == 0) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i = m0_cyc_i & $urandom_range(0, 1);
            m1_stb_i = m1_cyc_i & $urandom_range(0, 1);
            m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom);
            m0_we_i  = 1'($urandom);
            m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom);
            m1_we_i  = 1'($urandom);
            m1_bl_i  = BLW'($urandom); m1_bry_i = 1'($urandom);
            s_dat_i  = $urandom; s_ack_i = 1'($urandom); s_lack_i = 1'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_arbiter_2m1s.md
Name: wb_arbiter_2m1s

Overview:
- Wishbone interconnect between two masters and one slave.
- Master 0 is the instruction-cache port; master 1 is the data-cache port; the slave is unified memory.
- Arbitrates for the slave, muxes the granted master onto the slave bus, and routes the slave responses back to that master only.

Parameters:
- DW, 32, data bus width.
- AW, 32, address bus width.
- BLW, 10, burst-length field width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- m0_wbd_dat_i  in  DW  master-0 write data.
- m0_wbd_adr_i  in  AW  master-0 address.
- m0_wbd_sel_i  in  4  master-0 byte select.
- m0_wbd_we_i / m0_wbd_cyc_i / m0_wbd_stb_i  in  1 each  master-0 write enable / cycle / strobe.
- m0_wbd_dat_o  out  DW  read data to master 0.
- m0_wbd_ack_o / m0_wbd_lack_o / m0_wbd_err_o  out  1 each  ack / last-ack / error to master 0.
- m1_wbd_dat_i, m1_wbd_adr_i, m1_wbd_sel_i, m1_wbd_we_i, m1_wbd_cyc_i, m1_wbd_stb_i  in  same widths as master 0  master-1 request.
- m1_wbd_bl_i  in  BLW  master-1 burst length.
- m1_wbd_bry_i  in  1  master-1 burst ready.
- m1_wbd_dat_o, m1_wbd_ack_o, m1_wbd_lack_o, m1_wbd_err_o  out  as master 0  master-1 response.
- s_wbd_dat_i  in  DW  slave read data.
- s_wbd_ack_i / s_wbd_lack_i  in  1 each  slave ack / last-ack.
- s_wbd_dat_o, s_wbd_adr_o, s_wbd_sel_o, s_wbd_we_o, s_wbd_cyc_o, s_wbd_stb_o  out  muxed request to the slave.
- s_wbd_bl_o  out  BLW  muxed burst length.
- s_wbd_bry_o  out  1  muxed burst ready.

Behaviour:
- Grant state is registered, with encoding NONE / M0 / M1. Reset value is NONE, and reset asynchronously forces NONE mid-transaction.
- From NONE, at each clock edge:
  - only m0_cyc high -> M0.
  - only m1_cyc high -> M1.
  - both high -> round-robin: the master not served last wins. After reset, the last-served pointer is M0, so M1 wins the first tie.
- From M0 or M1:
  - Grant holds while the granted master's cyc stays high, including across multiple stb/ack beats.
  - When the granted master's cyc is low at an edge, the grant moves directly to the other master if its cyc is high (one-edge handoff), else to NONE.
- Request latency: a request from idle reaches the slave (s_cyc/s_stb high) one cycle after cyc is asserted.
- Slave request outputs are combinational muxes of the granted master:
  - s_cyc_o = granted cyc; s_stb_o = granted stb.
  - dat, adr, sel and we are taken from the granted master.
  - s_bl_o = m1_bl_i when M1; 10'd1 when M0.
  - s_bry_o = m1_bry_i when M1; 1 when M0.
  - In NONE, all slave outputs are 0.
- Response routing:
  - mX_ack_o = s_ack_i & grant==X; mX_lack_o = s_lack_i & grant==X.
  - mX_dat_o = s_wbd_dat_i for both masters (broadcast); only the ack qualifies it.
  - err_o is tied 0 for both masters. There is a single slave with full-range decode; addresses pass through unmodified.
- A non-granted master sees ack=0 and lack=0 regardless of slave activity, and its requests never reach the slave.
- No buffering: one outstanding transaction per grant, and the slave controls ack latency (a one-cycle registered ack is supported).
- Reset-state outputs: all slave outputs 0; all master ack/lack/err 0; dat_o equal to s_wbd_dat_i.

Test Plan:
- M0 read alone: m0 cyc/stb, adr=0x0000_0010; slave acks one cycle after s_cyc with dat=0x1234_5678 -> s_adr=0x10, s_we=0, s_bl=1, m0_ack pulse carrying 0x1234_5678, m1_ack=0 throughout.
- M1 write alone: adr=0x1000, dat=0x1, sel=0xF, we=1, bl=1 -> slave sees identical adr/dat/sel/we one cycle after cyc; m1_ack returns; m0_ack stays 0.
- Simultaneous requests immediately after reset: M1 granted first. When m1_cyc drops, M0 is granted at the same edge and s_adr switches to m0_adr with no idle cycle.
- Grant stability: with M0 granted, m1 asserts cyc mid-transaction -> s_adr stays m0_adr until m0_cyc drops; m1 is never acked early.
- Repeated ties: both masters hold cyc and each drops it for one cycle after every ack -> grants alternate M1, M0, M1, M0.
- Async reset mid-transfer: reset asserted between clock edges while M1 is granted -> s_cyc_o and s_stb_o fall immediately without a clock edge; grant returns to NONE and the tie pointer to its reset value.
